// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter: NREQ requesters share one FIFO write port.
// A grant is locked from a packet's first word through the word flagged LAST.
module fifo_wr_arb #(
  parameter int NREQ  = 4,
  parameter int width = 32
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ-1:0]       LAST,
  input  logic [NREQ*width-1:0] DIN,
  output logic [NREQ-1:0]       ACK,
  output logic [NREQ-1:0]       GNT,
  output logic                  BUSY,
  output logic [width-1:0]      FIFO_D,
  output logic                  FIFO_WR,
  input  logic                  FIFO_FULL
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [NREQ-1:0] gnt_q, gnt_d;

  logic [width-1:0] din_arr [NREQ];
  logic             owner_req;
  logic             owner_last;
  logic [width-1:0] owner_din;

  logic             pick_found;
  logic [PW-1:0]    pick_idx;
  logic [PW:0]      scan_sum;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_din
      assign din_arr[gi] = DIN[gi*width +: width];
    end
  endgenerate

  assign owner_req  = REQ[owner_q];
  assign owner_last = LAST[owner_q];
  assign owner_din  = din_arr[owner_q];

  // First set REQ bit at or above ptr_q, wrapping NREQ-1 -> 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr_q} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(NREQ)) begin
        scan_sum = scan_sum - (PW+1)'(NREQ);
      end
      if (!pick_found && REQ[scan_sum[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    FIFO_WR = 1'b0;
    FIFO_D  = '0;
    ACK     = '0;
    case (state_q)
      IDLE: begin
        // Arbitration cycle only; the first transfer happens once locked.
        if (pick_found) begin
          state_d = LOCK;
          owner_d = pick_idx;
          gnt_d   = NREQ'(1) << pick_idx;
        end
      end
      LOCK: begin
        FIFO_WR = owner_req & ~FIFO_FULL;
        FIFO_D  = owner_din;
        ACK     = gnt_q & {NREQ{FIFO_WR}};
        if (FIFO_WR && owner_last) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (owner_q == PW'(NREQ-1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
    end
  end

  assign GNT  = gnt_q;
  assign BUSY = (state_q == LOCK);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: expected FIFO writes are queued by the stimulus
// and a negedge monitor pops and compares them as the DUT writes.
module tb_fifo_wr_arb;
  localparam int N = 4;
  localparam int W = 32;

  logic           CLK = 1'b0;
  logic           nRST = 1'b1;
  logic [N-1:0]   REQ = '0;
  logic [N-1:0]   LAST = '0;
  logic [N*W-1:0] DIN = '0;
  logic           FIFO_FULL = 1'b0;
  logic [N-1:0]   ACK;
  logic [N-1:0]   GNT;
  logic           BUSY;
  logic [W-1:0]   FIFO_D;
  logic           FIFO_WR;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int           id;
    logic [W-1:0] data;
  } wr_t;
  wr_t sb[$];
  wr_t mon_e;

  logic [N-1:0] exp1 [5];

  always #5 CLK = ~CLK;

  fifo_wr_arb #(.NREQ(N), .width(W)) dut (
    .CLK(CLK), .nRST(nRST), .REQ(REQ), .LAST(LAST), .DIN(DIN),
    .ACK(ACK), .GNT(GNT), .BUSY(BUSY), .FIFO_D(FIFO_D),
    .FIFO_WR(FIFO_WR), .FIFO_FULL(FIFO_FULL)
  );

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic set_din(input int i, input logic [W-1:0] v);
    DIN[i*W +: W] = v;
  endtask

  task automatic push(input int id, input logic [W-1:0] d);
    wr_t e;
    e.id   = id;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    REQ = '0;
    LAST = '0;
    FIFO_FULL = 1'b0;
    next_cycle();
    nRST = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},  W'(GNT), 0);
    chk({tag, "_busy"}, W'(BUSY), 0);
    chk({tag, "_wr"},   W'(FIFO_WR), 0);
    chk({tag, "_ack"},  W'(ACK), 0);
    chk({tag, "_d"},    FIFO_D, 0);
  endtask

  // Monitor: invariants every cycle, plus scoreboard pop on every FIFO write.
  always @(negedge CLK) begin
    chk("gnt_onehot0", W'($onehot0(GNT)), W'(1));
    chk("wr_while_full", W'(FIFO_WR & FIFO_FULL), 0);
    chk("busy_vs_gnt", W'(BUSY), W'(|GNT));
    if (FIFO_WR) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got data %0h ack %0h, expected no write", FIFO_D, ACK);
      end else begin
        mon_e = sb.pop_front();
        $display("[TB] write req%0d data %0h", mon_e.id, FIFO_D);
        chk("wr_data", FIFO_D, mon_e.data);
        chk("wr_ack", W'(ACK), W'(N'(1) << mon_e.id));
      end
    end else begin
      chk("ack_no_write", W'(ACK), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp1[0] = 4'b0010; exp1[1] = 4'b0000; exp1[2] = 4'b1000;
    exp1[3] = 4'b0000; exp1[4] = 4'b0010;

    // Reset state
    #1 nRST = 1'b0;
    #2 chk_all_zero("reset");
    next_cycle();
    next_cycle();
    nRST = 1'b1;

    // Alternating single-word packets from requesters 1 and 3
    do_reset();
    set_din(1, 32'h1111_0001);
    set_din(3, 32'h3333_0003);
    REQ = 4'b1010; LAST = 4'b1111;
    push(1, 32'h1111_0001); push(3, 32'h3333_0003); push(1, 32'h1111_0001);
    smp(); chk("t1_gnt_c0", W'(GNT), 0);
    for (int c = 1; c <= 5; c++) begin
      next_cycle(); smp();
      chk($sformatf("t1_gnt_c%0d", c), W'(GNT), W'(exp1[c-1]));
    end
    next_cycle(); REQ = '0;
    smp(); chk("t1_gnt_end", W'(GNT), 0);

    // 3-word packet from requester 0 while requester 2 waits
    do_reset();
    set_din(0, 32'hA0A0_0000); set_din(2, 32'hC0C0_0000);
    REQ = 4'b0101; LAST = 4'b0000;
    push(0, 32'hA0A0_0000); push(0, 32'hA0A0_0001); push(0, 32'hA0A0_0002);
    push(2, 32'hC0C0_0000);
    smp(); chk("t2_gnt_c0", W'(GNT), 0);
    next_cycle(); smp(); chk("t2_gnt_c1", W'(GNT), 4'b0001);
    next_cycle(); set_din(0, 32'hA0A0_0001);
    smp(); chk("t2_gnt_c2", W'(GNT), 4'b0001);
    next_cycle(); set_din(0, 32'hA0A0_0002); LAST = 4'b0001;
    smp(); chk("t2_gnt_c3", W'(GNT), 4'b0001);
    next_cycle(); REQ = 4'b0100; LAST = 4'b0100;
    smp(); chk("t2_gnt_c4", W'(GNT), 0);
    next_cycle(); smp(); chk("t2_gnt_c5", W'(GNT), 4'b0100);
    next_cycle(); REQ = '0;
    smp(); chk("t2_gnt_end", W'(GNT), 0);

    // FIFO full for 5 cycles while requester 1 owns the lock
    do_reset();
    set_din(1, 32'hB0B0_0000);
    REQ = 4'b0010; LAST = 4'b0010;
    push(1, 32'hB0B0_0000);
    smp();
    for (int c = 1; c <= 5; c++) begin
      next_cycle(); FIFO_FULL = 1'b1;
      smp();
      chk($sformatf("t3_gnt_c%0d", c), W'(GNT), 4'b0010);
      chk($sformatf("t3_wr_c%0d", c), W'(FIFO_WR), 0);
      chk($sformatf("t3_ack_c%0d", c), W'(ACK), 0);
    end
    next_cycle(); FIFO_FULL = 1'b0;
    smp(); chk("t3_gnt_c6", W'(GNT), 4'b0010); chk("t3_wr_c6", W'(FIFO_WR), 1);
    next_cycle(); REQ = '0;
    smp(); chk("t3_gnt_end", W'(GNT), 0); chk("t3_busy_end", W'(BUSY), 0);

    // Owner 3 stalls mid-packet while requester 0 waits; pointer wraps to 0
    do_reset();
    set_din(2, 32'hC1C1_0000);
    REQ = 4'b0100; LAST = 4'b0100;
    push(2, 32'hC1C1_0000); push(3, 32'hD0D0_0000); push(3, 32'hD0D0_0001);
    push(0, 32'hE0E0_0000);
    smp(); chk("t4_gnt_c0", W'(GNT), 0);
    next_cycle(); smp(); chk("t4_gnt_c1", W'(GNT), 4'b0100);
    next_cycle();
    REQ = 4'b1001; LAST = 4'b0000;
    set_din(3, 32'hD0D0_0000); set_din(0, 32'hE0E0_0000);
    smp(); chk("t4_gnt_c2", W'(GNT), 0);
    next_cycle(); smp(); chk("t4_gnt_c3", W'(GNT), 4'b1000);
    for (int c = 4; c <= 6; c++) begin
      next_cycle(); REQ = 4'b0001;
      smp();
      chk($sformatf("t4_gnt_c%0d", c), W'(GNT), 4'b1000);
      chk($sformatf("t4_wr_c%0d", c), W'(FIFO_WR), 0);
    end
    next_cycle(); REQ = 4'b1001; LAST = 4'b1000; set_din(3, 32'hD0D0_0001);
    smp(); chk("t4_gnt_c7", W'(GNT), 4'b1000);
    next_cycle(); REQ = 4'b0001; LAST = 4'b0001;
    smp(); chk("t4_gnt_c8", W'(GNT), 0);
    next_cycle(); smp(); chk("t4_gnt_c9", W'(GNT), 4'b0001);
    next_cycle(); REQ = '0;
    smp(); chk("t4_gnt_end", W'(GNT), 0);

    // Reset pulsed during word 2 of a packet
    do_reset();
    set_din(0, 32'hF0F0_0000);
    REQ = 4'b0001; LAST = 4'b0000;
    push(0, 32'hF0F0_0000);
    smp();
    next_cycle(); smp(); chk("t5_gnt_c1", W'(GNT), 4'b0001);
    next_cycle(); set_din(0, 32'hF0F0_0001);
    nRST = 1'b0;
    #1 chk_all_zero("t5_midreset");
    smp();
    next_cycle(); nRST = 1'b1;
    REQ = 4'b1111; LAST = 4'b1111;
    set_din(0, 32'h6060_0000); set_din(1, 32'h6161_0000);
    set_din(2, 32'h6262_0000); set_din(3, 32'h6363_0000);
    push(0, 32'h6060_0000);
    smp(); chk("t5_gnt_idle", W'(GNT), 0);
    next_cycle(); smp(); chk("t5_gnt_first", W'(GNT), 4'b0001);
    next_cycle(); REQ = '0;
    smp(); chk("t5_gnt_end", W'(GNT), 0);

    next_cycle(); next_cycle();
    chk("sb_empty", W'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
